// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN inference sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CLEAR,
    LOAD_D,
    WAIT_RES
  } state_e;

  localparam logic MODE_WEIGHT = 1'b1;
  localparam logic MODE_DATA   = 1'b0;

  localparam int W_BYTES_DEF = 54;
  localparam int D_BYTES_DEF = 64;

endpackage

// File: rtl/res_fifo.sv
// Small synchronous FIFO for captured result bytes; flush drops all entries.
module res_fifo #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [1<<PW];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cnn_infer_sequencer.sv
// Host-side sequencer: loads weights/image into the CNN core, clears it per
// image, and returns the captured result bytes over a valid/ready port.
module cnn_infer_sequencer
  import cnn_pkg::*;
#(
  parameter int W_BYTES    = W_BYTES_DEF,
  parameter int D_BYTES    = D_BYTES_DEF,
  parameter int RES_BYTES  = 1,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_load_w,
  output logic       cmd_ready,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       core_mode,
  output logic       core_ram_en,
  output logic [7:0] core_din,
  output logic       core_rst_n,
  input  logic [7:0] core_dout,
  input  logic       core_out_flag,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       busy,
  output logic       err_timeout
);

  localparam int CW = $clog2(((W_BYTES > D_BYTES) ? W_BYTES : D_BYTES) + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RES_BYTES + 1);

  state_e        state, state_d;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [RW-1:0] cap_cnt;
  logic          w_loaded;
  logic          armed;
  logic          cmd_acc, s_acc, cap, to_hit;
  logic          fifo_empty, fifo_full;

  // armed keeps cmd_ready low while reset is asserted.
  assign cmd_ready = armed && (state == IDLE) && fifo_empty;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign s_acc     = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign m_valid   = !fifo_empty;

  always_comb begin
    state_d = state;
    s_ready = 1'b0;
    cap     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE:
        if (cmd_acc) state_d = (cmd_load_w || !w_loaded) ? LOAD_W : CLEAR;
      LOAD_W: begin
        s_ready = 1'b1;
        if (s_valid && cnt == CW'(W_BYTES - 1)) state_d = CLEAR;
      end
      CLEAR:
        if (cnt == CW'(CLR_CYCLES - 1)) state_d = LOAD_D;
      LOAD_D: begin
        s_ready = 1'b1;
        if (s_valid && cnt == CW'(D_BYTES - 1)) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        cap = core_out_flag;
        // A final capture on the timeout cycle wins over the timeout.
        if (cap && cap_cnt == RW'(RES_BYTES - 1)) begin
          state_d = IDLE;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          to_hit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      cap_cnt     <= '0;
      w_loaded    <= 1'b0;
      armed       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_d;
      if (state_d != state)             cnt <= '0;
      else if (s_acc || state == CLEAR) cnt <= cnt + 1'b1;
      tmr     <= (state == WAIT_RES && state_d == WAIT_RES) ? tmr + 1'b1 : '0;
      if (state != WAIT_RES) cap_cnt <= '0;
      else if (cap)          cap_cnt <= cap_cnt + 1'b1;
      if (state == LOAD_W && state_d == CLEAR) w_loaded <= 1'b1;
      if (cmd_acc)     err_timeout <= 1'b0;
      else if (to_hit) err_timeout <= 1'b1;
    end
  end

  // Core strobes lag the stream handshake by one cycle; core_rst_n is
  // registered too so the clear window stays aligned with the write stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_mode   <= 1'b0;
      core_ram_en <= 1'b0;
      core_din    <= '0;
      core_rst_n  <= 1'b1;
    end else begin
      core_ram_en <= s_acc;
      core_rst_n  <= (state != CLEAR);
      if (s_acc) begin
        core_mode <= (state == LOAD_W) ? MODE_WEIGHT : MODE_DATA;
        core_din  <= s_data;
      end
    end
  end

  res_fifo #(.DEPTH(RES_BYTES), .DW(8)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (to_hit),
    .push  (cap),
    .wdata (core_dout),
    .pop   (m_ready),
    .rdata (m_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_cnn_infer_sequencer.sv
// Randomized bench for cnn_infer_sequencer against a transaction-level model.
module tb_cnn_infer_sequencer;

  localparam int WB = 54;
  localparam int DB = 64;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0, cmd_load_w = 1'b0, cmd_ready;
  logic       s_valid = 1'b0, s_ready;
  logic [7:0] s_data = '0;
  logic       core_mode, core_ram_en, core_rst_n;
  logic [7:0] core_din;
  logic [7:0] core_dout = '0;
  logic       core_out_flag = 1'b0;
  logic       m_valid, m_ready = 1'b0;
  logic [7:0] m_data;
  logic       busy, err_timeout;

  always #5 clk = ~clk;

  cnn_infer_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_load_w(cmd_load_w), .cmd_ready(cmd_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_mode(core_mode), .core_ram_en(core_ram_en), .core_din(core_din),
    .core_rst_n(core_rst_n), .core_dout(core_dout), .core_out_flag(core_out_flag),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state: what the core should have seen, and whether weights are held.
  logic [8:0] mon_q[$];
  logic [8:0] exp_q[$];
  int  rst_lo, en_in_rst, bad_mv, bad_sr;
  bit  w_loaded_m = 1'b0;

  always @(negedge clk) begin
    if (core_ram_en === 1'b1) mon_q.push_back({core_mode, core_din});
    if (core_rst_n === 1'b0) begin
      rst_lo++;
      if (core_ram_en === 1'b1) en_in_rst++;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_core"}, 32'({core_mode, core_ram_en, core_din}), 0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 1);
    chk({tag, "_m"}, 32'({m_valid, m_data}), 0);
    chk({tag, "_busy_err"}, 32'({busy, err_timeout}), 0);
  endtask

  task automatic issue_cmd(input bit lw);
    int g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 1000) begin @(negedge clk); g++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_load_w = lw;
    @(posedge clk);
    mon_q.delete(); rst_lo = 0; en_in_rst = 0; bad_mv = 0; bad_sr = 0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_load_w = 1'b0;
    chk("err_clr_on_cmd", 32'(err_timeout), 0);
    chk("busy_after_cmd", 32'(busy), 1);
  endtask

  // Offers bytes continuously (with random gaps); returns at a negedge.
  task automatic stream(input int nw, input int gap, input bit spur, input int abort_at,
                        output bit aborted);
    int idx = 0, g = 0, n;
    bit acc;
    n = nw + DB;
    aborted = 1'b0;
    while (idx < n && g < 4000) begin
      if (abort_at >= 0 && idx == nw + abort_at) begin
        rst_n = 1'b0; s_valid = 1'b0; core_out_flag = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (m_valid) bad_mv++;
      if (idx > nw && !s_ready) bad_sr++;
      s_valid = (int'($urandom_range(0, 99)) >= gap);
      s_data  = 8'($urandom);
      core_out_flag = spur && idx >= nw && ($urandom_range(0, 3) == 0);
      core_dout = 8'($urandom);
      acc = s_valid && s_ready;
      if (acc) exp_q.push_back({(idx < nw), s_data});
      @(posedge clk);
      if (acc) idx++;
      g++;
      @(negedge clk);
    end
    s_valid = 1'b0; core_out_flag = 1'b0;
    chk("stream_done", idx, n);
    chk("s_ready_in_wait", 32'(s_ready), 0);
    chk("busy_in_wait", 32'(busy), 1);
  endtask

  task automatic run_image(input bit lw, input int gap, input bit spur, input int delay,
                           input int abort_at, input logic [7:0] dout);
    bit need_w, ab;
    int nw, cyc;
    need_w = lw || !w_loaded_m;
    nw = need_w ? WB : 0;
    issue_cmd(lw);
    chk("weight_phase_entry", 32'(s_ready), 32'(need_w));
    exp_q.delete();
    stream(nw, gap, spur, abort_at, ab);
    if (ab) begin
      w_loaded_m = 1'b0;
      return;
    end
    if (need_w) w_loaded_m = 1'b1;
    if (delay >= 0) begin
      repeat (delay) @(negedge clk);
      core_out_flag = 1'b1; core_dout = dout;
      @(negedge clk);
      core_out_flag = 1'b0; core_dout = 8'($urandom);
      chk("res_valid", 32'(m_valid), 1);
      chk("res_data", 32'(m_data), 32'(dout));
      chk("res_state", 32'({busy, err_timeout, cmd_ready}), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("cmd_blocked", 32'(cmd_ready), 0);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("res_popped", 32'(m_valid), 0);
      chk("cmd_ready_after_pop", 32'(cmd_ready), 1);
    end else begin
      cyc = 0;
      while (busy && cyc < 400) begin cyc++; @(negedge clk); end
      chk("timeout_cycles", cyc, TO);
      chk("timeout_err", 32'(err_timeout), 1);
      chk("timeout_m_valid", 32'(m_valid), 0);
    end
    chk("core_wr_count", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk("core_wr", 32'(mon_q[i]), 32'(exp_q[i]));
    chk("clear_cycles", rst_lo, 2);
    chk("write_in_clear", en_in_rst, 0);
    chk("m_valid_quiet", bad_mv, 0);
    chk("s_ready_gapless", bad_sr, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);

    run_image(1'b0, 0, 1'b0, 20, -1, 8'h5A);
    run_image(1'b0, 0, 1'b0, int'($urandom_range(0, 100)), -1, 8'($urandom));
    run_image(1'b0, 50, 1'b0, int'($urandom_range(0, 100)), -1, 8'($urandom));
    run_image(1'b0, 0, 1'b0, -1, -1, 8'h00);
    run_image(1'b0, 30, 1'b0, 5, -1, 8'($urandom));
    run_image(1'b0, 0, 1'b0, 0, 30, 8'h00);
    run_image(1'b0, 0, 1'b0, 10, -1, 8'($urandom));
    run_image(1'b0, 40, 1'b1, 15, -1, 8'($urandom));
    run_image(1'b1, 0, 1'b0, TO - 1, -1, 8'hC3);
    run_image(1'b0, 10, 1'b0, 0, -1, 8'hFF);
    for (int k = 0; k < 5; k++)
      run_image(1'($urandom_range(0, 1)), int'($urandom_range(0, 60)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 200)), -1, 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
